alu_seq: RTL and testbench

Sequencing controller for the 8-bit ALU datapath in the CPU model. It accepts one instruction at a time (opcode plus 8-bit operand) and latches the operand onto the ALU data input. It drives the ALU's active-low operation selects and enable for a fixed execute window, then writes the ALU result back into the accumulator it owns. It sits between the instruction decoder and the ALU; the accumulator register feeding the ALU accum input lives here.

---
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequencing controller for the 8-bit ALU datapath.
// Owns the accumulator and drives registered active-low ALU selects.
module alu_seq #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [DW-1:0]    operand,
  input  logic [DW-1:0]    alu_out,
  output logic [DW-1:0]    data_q,
  output logic [DW-1:0]    accum,
  output logic             IADD,
  output logic             ISUB,
  output logic             IAND,
  output logic             IOR,
  output logic             EALU,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             illegal,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       op_q, op_nx;
  logic [DW-1:0]    data_nx, accum_nx;
  logic             zero_nx, busy_nx;
  logic             done_nx, illegal_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [3:0]       sel_q, sel_nx;
  logic             wr;
  logic [DW-1:0]    wr_val;

  // {IADD, ISUB, IAND, IOR}, active low
  function automatic logic [3:0] sel_of(
    input logic [2:0] op
  );
    sel_of = 4'hF;
    unique case (op)
      OP_ADD:  sel_of = 4'b0111;
      OP_SUB:  sel_of = 4'b1011;
      OP_AND:  sel_of = 4'b1101;
      OP_OR:   sel_of = 4'b1110;
      default: sel_of = 4'hF;
    endcase
  endfunction

  always_comb begin
    wr     = 1'b1;
    wr_val = alu_out;
    unique case (1'b1)
      (op_q == OP_LDA): wr_val = data_q;
      (op_q == OP_CLR): wr_val = '0;
      (op_q == OP_NOP): wr     = 1'b0;
      (op_q == OP_ILL): wr     = 1'b0;
      default:          wr     = 1'b1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    op_nx      = op_q;
    data_nx    = data_q;
    accum_nx   = accum;
    zero_nx    = zero;
    busy_nx    = busy;
    done_nx    = 1'b0;
    illegal_nx = 1'b0;
    cnt_nx     = op_cnt;
    sel_nx     = 4'hF;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = EXEC;
          op_nx    = opcode;
          data_nx  = operand;
          busy_nx  = 1'b1;
          sel_nx   = sel_of(opcode);
        end
      end
      EXEC: begin
        state_nx = WB;
        sel_nx   = sel_of(op_q);
      end
      WB: begin
        state_nx   = IDLE;
        busy_nx    = 1'b0;
        done_nx    = 1'b1;
        illegal_nx = (op_q == OP_ILL);
        if (!(&op_cnt))
          cnt_nx = op_cnt + CNT_W'(1);
        if (wr) begin
          accum_nx = wr_val;
          zero_nx  = (wr_val == '0);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      accum   <= '0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      op_cnt  <= '0;
      sel_q   <= 4'hF;
      EALU    <= 1'b1;
    end else begin
      state   <= state_nx;
      op_q    <= op_nx;
      data_q  <= data_nx;
      accum   <= accum_nx;
      zero    <= zero_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      illegal <= illegal_nx;
      op_cnt  <= cnt_nx;
      sel_q   <= sel_nx;
      EALU    <= &sel_nx;
    end
  end

  assign IADD = sel_q[3];
  assign ISUB = sel_q[2];
  assign IAND = sel_q[1];
  assign IOR  = sel_q[0];

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq
// against a behavioural accumulator model and an ALU model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [7:0] operand = 8'd0;

  logic [7:0] alu_out, data_q, accum;
  logic       IADD, ISUB, IAND, IOR, EALU;
  logic       busy, done, zero, illegal;
  logic [7:0] op_cnt;

  logic [7:0] s_alu, s_data, s_acc;
  logic       s_iadd, s_isub, s_iand, s_ior, s_ealu;
  logic       s_busy, s_done, s_zero, s_ill;
  logic [1:0] s_op_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_acc;
  int         m_cnt;
  int         m_sat;

  wire [4:0] sel = {IADD, ISUB, IAND, IOR, EALU};

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] d,
    input logic [4:0] s
  );
    case (s)
      5'b01110: alu_f = a + d;
      5'b10110: alu_f = d - a;
      5'b11010: alu_f = a & d;
      5'b11100: alu_f = a | d;
      default:  alu_f = 8'h5A;
    endcase
  endfunction

  function automatic logic [4:0] exp_sel(
    input logic [2:0] op
  );
    case (op)
      3'd1:    exp_sel = 5'b01110;
      3'd2:    exp_sel = 5'b10110;
      3'd3:    exp_sel = 5'b11010;
      3'd4:    exp_sel = 5'b11100;
      default: exp_sel = 5'b11111;
    endcase
  endfunction

  assign alu_out = alu_f(accum, data_q, sel);
  assign s_alu = alu_f(s_acc, s_data,
    {s_iadd, s_isub, s_iand, s_ior, s_ealu});

  alu_seq u_dut (
    .clk(clk), .rst(rst), .start(start),
    .opcode(opcode), .operand(operand),
    .alu_out(alu_out), .data_q(data_q),
    .accum(accum), .IADD(IADD), .ISUB(ISUB),
    .IAND(IAND), .IOR(IOR), .EALU(EALU),
    .busy(busy), .done(done), .zero(zero),
    .illegal(illegal), .op_cnt(op_cnt)
  );

  alu_seq #(.DW(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start),
    .opcode(opcode), .operand(operand),
    .alu_out(s_alu), .data_q(s_data),
    .accum(s_acc), .IADD(s_iadd), .ISUB(s_isub),
    .IAND(s_iand), .IOR(s_ior), .EALU(s_ealu),
    .busy(s_busy), .done(s_done), .zero(s_zero),
    .illegal(s_ill), .op_cnt(s_op_cnt)
  );

  task automatic model_apply(
    input logic [2:0] op,
    input logic [7:0] v
  );
    case (op)
      3'd1: m_acc = m_acc + v;
      3'd2: m_acc = v - m_acc;
      3'd3: m_acc = m_acc & v;
      3'd4: m_acc = m_acc | v;
      3'd5: m_acc = v;
      3'd6: m_acc = 8'd0;
      default: ;
    endcase
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_sat = (m_sat < 3) ? m_sat + 1 : 3;
  endtask

  task automatic model_reset();
    m_acc = 8'd0;
    m_cnt = 0;
    m_sat = 0;
  endtask

  task automatic issue(
    input logic [2:0] op,
    input logic [7:0] v,
    input bit         noise
  );
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    operand = v;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      opcode = 3'($urandom);
      operand = 8'($urandom);
    end
    checks++;
    if ({sel, busy, done, data_q} !==
        {exp_sel(op), 1'b1, 1'b0, v}) begin
      errors++;
      $display("FAIL exec op=%0d got=%h exp=%h", op,
        {sel, busy, done, data_q},
        {exp_sel(op), 1'b1, 1'b0, v});
    end
    @(posedge clk); #1;
    if (noise) begin
      opcode = 3'($urandom);
      operand = 8'($urandom);
    end
    checks++;
    if ({sel, busy, done} !== {exp_sel(op), 2'b10}) begin
      errors++;
      $display("FAIL wb op=%0d got=%b exp=%b", op,
        {sel, busy, done}, {exp_sel(op), 2'b10});
    end
    @(posedge clk); #1;
    start = 1'b0;
    model_apply(op, v);
    checks++;
    if ({accum, zero, busy, done, illegal, sel} !==
        {m_acc, m_acc == 8'd0, 1'b0, 1'b1,
         op == 3'd7, 5'b11111}) begin
      errors++;
      $display("FAIL done op=%0d got=%h exp=%h", op,
        {accum, zero, busy, done, illegal, sel},
        {m_acc, m_acc == 8'd0, 1'b0, 1'b1,
         op == 3'd7, 5'b11111});
    end
    checks++;
    if (op_cnt !== 8'(m_cnt) || s_op_cnt !== 2'(m_sat)) begin
      errors++;
      $display("FAIL cnt got=%0d/%0d exp=%0d/%0d",
        op_cnt, s_op_cnt, m_cnt, m_sat);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, illegal, busy} !== 3'b000) begin
      errors++;
      $display("FAIL post op=%0d got=%b exp=000", op,
        {done, illegal, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({accum, data_q, zero, busy, done, illegal, sel,
         op_cnt, s_op_cnt} !==
        {8'h00, 8'h00, 4'b1000, 5'b11111, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset got=%h", {accum, data_q, zero,
        busy, done, illegal, sel, op_cnt, s_op_cnt});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add();
    issue(3'd5, 8'h05, 0);
    checks++;
    if (accum !== 8'h05) begin
      errors++;
      $display("FAIL lda got=%h exp=05", accum);
    end
    issue(3'd1, 8'hFE, 0);
    checks++;
    if ({accum, zero, op_cnt} !== {8'h03, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL add_wrap got=%h exp=%h",
        {accum, zero, op_cnt}, {8'h03, 1'b0, 8'd2});
    end
  endtask

  task automatic test_logic();
    issue(3'd5, 8'h0F, 0);
    issue(3'd2, 8'h10, 0);
    checks++;
    if (accum !== 8'h01) begin
      errors++;
      $display("FAIL sub got=%h exp=01", accum);
    end
    issue(3'd5, 8'h0F, 0);
    issue(3'd3, 8'h3C, 0);
    checks++;
    if (accum !== 8'h0C) begin
      errors++;
      $display("FAIL and got=%h exp=0c", accum);
    end
    issue(3'd4, 8'hF0, 0);
    checks++;
    if (accum !== 8'hFC) begin
      errors++;
      $display("FAIL or got=%h exp=fc", accum);
    end
  endtask

  task automatic test_zero();
    issue(3'd5, 8'h80, 0);
    issue(3'd1, 8'h80, 0);
    checks++;
    if ({accum, zero} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL zero_add got=%h exp=001",
        {accum, zero});
    end
    issue(3'd5, 8'h42, 0);
    issue(3'd6, 8'h99, 0);
    issue(3'd5, 8'h37, 0);
    issue(3'd0, 8'hAA, 0);
    checks++;
    if ({accum, zero} !== {8'h37, 1'b0}) begin
      errors++;
      $display("FAIL nop got=%h exp=%h",
        {accum, zero}, {8'h37, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int dcnt;
    issue(3'd6, 8'h00, 0);
    dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    opcode = 3'd1;
    operand = 8'h01;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b0;
      if (done === 1'b1) dcnt++;
    end
    model_apply(3'd1, 8'h01);
    model_apply(3'd1, 8'h01);
    checks++;
    if (dcnt !== 2 || accum !== m_acc ||
        op_cnt !== 8'(m_cnt)) begin
      errors++;
      $display("FAIL b2b dones=%0d acc=%h cnt=%0d exp=2/%h/%0d",
        dcnt, accum, op_cnt, m_acc, m_cnt);
    end
  endtask

  task automatic test_illegal();
    issue(3'd5, 8'h6B, 0);
    issue(3'd7, 8'h11, 0);
    checks++;
    if (accum !== 8'h6B) begin
      errors++;
      $display("FAIL illegal_acc got=%h exp=6b", accum);
    end
  endtask

  task automatic test_saturation();
    checks++;
    if (s_op_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat got=%0d exp=3", s_op_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      issue(3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    issue(3'd5, 8'h44, 0);
    @(negedge clk);
    start = 1'b1;
    opcode = 3'd1;
    operand = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if ({accum, zero, busy, done, illegal, sel, op_cnt} !==
        {8'h00, 4'b1000, 5'b11111, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid got=%h", {accum, zero, busy,
        done, illegal, sel, op_cnt});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({done, busy, accum} !== {2'b00, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid_post got=%h exp=000",
        {done, busy, accum});
    end
    issue(3'd1, 8'h21, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_logic();
    test_zero();
    test_back_to_back();
    test_illegal();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
